ps2_grid_cursor: RTL and testbench

PS2_GRID_CURSOR -- requirements
Module: ps2_grid_cursor

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/grid_axis.sv | 74 +++++++
 rtl/ps2_grid_cursor.sv | 146 ++++++++++++++
 tb/tb_ps2_grid_cursor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: packet FSM states and byte0 bit layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } ps2_state_t;

  // byte0 bit positions
  localparam int BTN_L  = 0;
  localparam int BTN_M  = 2;
  localparam int SYNC   = 3;
  localparam int X_SIGN = 4;
  localparam int Y_SIGN = 5;
  localparam int X_OVF  = 6;
  localparam int Y_OVF  = 7;

  // 9-bit signed axis movement; an overflowed axis is dropped entirely
  function automatic logic signed [8:0] ps2_delta(input logic sgn, input logic ovf,
                                                   input logic [7:0] mag);
    return ovf ? 9'sd0 : $signed({sgn, mag});
  endfunction

endpackage

// File: rtl/grid_axis.sv
// One cursor axis: tick accumulator with saturation, hysteresis stepping and edge handling.
module grid_axis #(
  parameter int LEN        = 128,
  parameter int PW         = 7,
  parameter int ACC_W      = 11,
  parameter int THRESHOLD  = 20,
  parameter int CELL_TICKS = 15,
  parameter int WRAP_EN    = 0,
  parameter int POS_DEC    = 0   // 1: positive ticks move toward lower cell index
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,   // packet cycle: accumulate only, no step
  input  logic signed [9:0]   delta,
  output logic [PW-1:0]       pos,
  output logic                moved
);

  localparam int MAXV = 2**(ACC_W-1) - 1;
  localparam logic signed [ACC_W:0]   SMAX = (ACC_W+1)'(MAXV);
  localparam logic signed [ACC_W:0]   SMIN = (ACC_W+1)'(-MAXV);
  localparam logic signed [ACC_W-1:0] THR  = ACC_W'(THRESHOLD);
  localparam logic signed [ACC_W-1:0] NTHR = ACC_W'(-THRESHOLD);
  localparam logic signed [ACC_W-1:0] TICK = ACC_W'(CELL_TICKS);

  logic signed [ACC_W-1:0] acc, acc_nx;
  logic signed [ACC_W:0]   sum;
  logic [PW-1:0]           pos_nx;
  logic                    mv, up, dn, inc, dec, at_hi, at_lo;

  assign sum   = {acc[ACC_W-1], acc} + {{(ACC_W-9){delta[9]}}, delta};
  assign up    = acc >= THR;
  assign dn    = acc <= NTHR;
  assign inc   = (POS_DEC != 0) ? dn : up;
  assign dec   = (POS_DEC != 0) ? up : dn;
  assign at_hi = pos == PW'(LEN-1);
  assign at_lo = pos == '0;

  // accumulate on packets, otherwise drain one cell step; edges clamp or wrap
  always_comb begin
    acc_nx = acc;
    pos_nx = pos;
    mv     = 1'b0;
    if (load) begin
      if (sum > SMAX)      acc_nx = SMAX[ACC_W-1:0];
      else if (sum < SMIN) acc_nx = SMIN[ACC_W-1:0];
      else                 acc_nx = sum[ACC_W-1:0];
    end else begin
      if (up)      acc_nx = acc - TICK;
      else if (dn) acc_nx = acc + TICK;
      if (inc) begin
        if (!at_hi)            begin pos_nx = pos + PW'(1); mv = 1'b1; end
        else if (WRAP_EN != 0) begin pos_nx = '0;           mv = 1'b1; end
      end else if (dec) begin
        if (!at_lo)            begin pos_nx = pos - PW'(1);   mv = 1'b1; end
        else if (WRAP_EN != 0) begin pos_nx = PW'(LEN-1);     mv = 1'b1; end
      end
    end
  end

  // axis state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      pos   <= '0;
      moved <= 1'b0;
    end else begin
      acc   <= acc_nx;
      pos   <= pos_nx;
      moved <= mv;
    end
  end

endmodule

// File: rtl/ps2_grid_cursor.sv
// PS/2 mouse packet decoder driving a grid cursor with per-axis tick accumulation.
module ps2_grid_cursor
  import ps2_pkg::*;
#(
  parameter int GRID_W      = 128,
  parameter int GRID_H      = 96,
  parameter int CELL_TICKS  = 15,
  parameter int HYSTERESIS  = 5,
  parameter int WHEEL_EN    = 0,
  parameter int WRAP_EN     = 0,
  parameter int TIMEOUT_CYC = 50000,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_err,
  input  logic          invert_y,
  output logic [XW-1:0] cell_x,
  output logic [YW-1:0] cell_y,
  output logic [2:0]    buttons,
  output logic [3:0]    wheel,
  output logic          pkt_valid,
  output logic          move_valid,
  output logic          sync_err
);

  localparam int THRESHOLD = CELL_TICKS + HYSTERESIS;
  localparam int ACC_W     = $clog2(THRESHOLD + 512) + 1;
  localparam int TW        = $clog2(TIMEOUT_CYC + 1) + 1;

  ps2_state_t state, state_nx;
  logic [TW-1:0]   tmo;
  logic            tmo_exp, abort_c;
  logic            cap0, cap1, cap2, cap3, done, drop, abort;
  logic [2:0]      btn_q;
  logic            xs_q, ys_q, xo_q, yo_q;
  logic [7:0]      b1_q, b2_q;
  logic [3:0]      b3_q;
  logic signed [8:0] dx, dy;
  logic signed [9:0] dx_w, dy_w;
  logic            mv_x, mv_y;

  assign tmo_exp = !rx_valid && (tmo == TW'(TIMEOUT_CYC));
  assign abort_c = rx_err || tmo_exp;

  // packet state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= B0;
    else       state <= state_nx;
  end

  // byte sequencing: sync check on byte0, abort on error/timeout mid-packet
  always_comb begin
    state_nx = state;
    cap0 = 1'b0; cap1 = 1'b0; cap2 = 1'b0; cap3 = 1'b0;
    done = 1'b0; drop = 1'b0; abort = 1'b0;
    case (state)
      B0: if (rx_valid) begin
        if (rx_data[SYNC]) begin cap0 = 1'b1; state_nx = B1; end
        else drop = 1'b1;
      end
      B1: if (abort_c) begin abort = 1'b1; state_nx = B0; end
          else if (rx_valid) begin cap1 = 1'b1; state_nx = B2; end
      B2: if (abort_c) begin abort = 1'b1; state_nx = B0; end
          else if (rx_valid) begin
            cap2 = 1'b1;
            if (WHEEL_EN != 0) state_nx = B3;
            else begin done = 1'b1; state_nx = B0; end
          end
      B3: if (abort_c) begin abort = 1'b1; state_nx = B0; end
          else if (rx_valid) begin cap3 = 1'b1; done = 1'b1; state_nx = B0; end
      default: state_nx = B0;
    endcase
  end

  // inter-byte gap counter, only meaningful while a packet is open
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                        tmo <= '0;
    else if (state == B0 || rx_valid) tmo <= '0;
    else if (!tmo_exp)                tmo <= tmo + TW'(1);
  end

  // packet byte capture
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      btn_q <= '0; xs_q <= 1'b0; ys_q <= 1'b0; xo_q <= 1'b0; yo_q <= 1'b0;
      b1_q  <= '0; b2_q <= '0;   b3_q <= '0;
    end else begin
      if (cap0) begin
        btn_q <= rx_data[BTN_M:BTN_L];
        xs_q  <= rx_data[X_SIGN];
        ys_q  <= rx_data[Y_SIGN];
        xo_q  <= rx_data[X_OVF];
        yo_q  <= rx_data[Y_OVF];
      end
      if (cap1) b1_q <= rx_data;
      if (cap2) b2_q <= rx_data;
      if (cap3) b3_q <= rx_data[3:0];
    end
  end

  // strobes and per-packet outputs; outputs latch in the pkt_valid cycle
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
      buttons   <= '0;
      wheel     <= '0;
    end else begin
      pkt_valid <= done;
      sync_err  <= drop | abort;
      if (pkt_valid) begin
        buttons <= btn_q;
        wheel   <= (WHEEL_EN != 0) ? b3_q : 4'd0;
      end
    end
  end

  assign dx   = ps2_delta(xs_q, xo_q, b1_q);
  assign dy   = ps2_delta(ys_q, yo_q, b2_q);
  assign dx_w = {dx[8], dx};
  assign dy_w = invert_y ? -{dy[8], dy} : {dy[8], dy};

  grid_axis #(
    .LEN(GRID_W), .PW(XW), .ACC_W(ACC_W), .THRESHOLD(THRESHOLD),
    .CELL_TICKS(CELL_TICKS), .WRAP_EN(WRAP_EN), .POS_DEC(0)
  ) u_ax_x (
    .clk(CLOCK_50), .rst(reset), .load(pkt_valid), .delta(dx_w),
    .pos(cell_x), .moved(mv_x)
  );

  // screen Y grows downward, so positive mouse Y moves toward row 0
  grid_axis #(
    .LEN(GRID_H), .PW(YW), .ACC_W(ACC_W), .THRESHOLD(THRESHOLD),
    .CELL_TICKS(CELL_TICKS), .WRAP_EN(WRAP_EN), .POS_DEC(1)
  ) u_ax_y (
    .clk(CLOCK_50), .rst(reset), .load(pkt_valid), .delta(dy_w),
    .pos(cell_y), .moved(mv_y)
  );

  assign move_valid = mv_x | mv_y;

endmodule

// File: tb/tb_ps2_grid_cursor.sv
// Scoreboard bench: expected events queued with stimulus, popped as the DUT strobes.
module tb_ps2_grid_cursor;

  localparam int TO = 40;
  localparam int EV_SYNC = 0, EV_PKT = 1, EV_MOVE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, rst2 = 1'b0;
  logic [7:0] rxd = '0, rxd2 = '0;
  logic       rxv = 1'b0, rxv2 = 1'b0, rxe = 1'b0, rxe2 = 1'b0, inv = 1'b0;
  logic [6:0] cx0, cx1, cx2, cy0, cy1, cy2;
  logic [2:0] bt0, bt1, bt2;
  logic [3:0] wh0, wh1, wh2;
  logic       pv0, pv1, pv2, mv0, mv1, mv2, se0, se1, se2;

  ps2_grid_cursor #(.TIMEOUT_CYC(TO)) d0 (
    .CLOCK_50(clk), .reset(rst), .rx_data(rxd), .rx_valid(rxv), .rx_err(rxe),
    .invert_y(inv), .cell_x(cx0), .cell_y(cy0), .buttons(bt0), .wheel(wh0),
    .pkt_valid(pv0), .move_valid(mv0), .sync_err(se0));

  ps2_grid_cursor #(.TIMEOUT_CYC(TO), .WRAP_EN(1)) d1 (
    .CLOCK_50(clk), .reset(rst), .rx_data(rxd), .rx_valid(rxv), .rx_err(rxe),
    .invert_y(inv), .cell_x(cx1), .cell_y(cy1), .buttons(bt1), .wheel(wh1),
    .pkt_valid(pv1), .move_valid(mv1), .sync_err(se1));

  ps2_grid_cursor #(.TIMEOUT_CYC(TO), .WHEEL_EN(1)) d2 (
    .CLOCK_50(clk), .reset(rst2), .rx_data(rxd2), .rx_valid(rxv2), .rx_err(rxe2),
    .invert_y(inv), .cell_x(cx2), .cell_y(cy2), .buttons(bt2), .wheel(wh2),
    .pkt_valid(pv2), .move_valid(mv2), .sync_err(se2));

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int kind; int a; int b; } ev_t;
  ev_t q[$];

  task automatic push(input int k, input int a, input int b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int k, input int a, input int b);
    ev_t e;
    if (q.size() == 0) chk("unexpected_evt", k, -1);
    else begin
      e = q.pop_front();
      chk("evt_kind", k, e.kind);
      if (e.kind == k && k == EV_PKT) begin
        chk("pkt_btn", a, e.a);
        chk("pkt_wheel", b, e.b);
      end else if (e.kind == k && k == EV_MOVE) begin
        chk("move_x", a, e.a);
        chk("move_y", b, e.b);
      end
    end
  endtask

  // d0 monitor: buttons/wheel are checked the cycle after pkt_valid
  logic pv_d = 1'b0;
  always @(negedge clk) begin
    if (pv_d) pop_chk(EV_PKT, int'(bt0), int'(wh0));
    if (se0)  pop_chk(EV_SYNC, 0, 0);
    if (mv0)  pop_chk(EV_MOVE, int'(cx0), int'(cy0));
    pv_d <= pv0;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // gap = idle clock edges before the next byte may be presented
  task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
    if (sel == 0) begin rxd = b; rxv = 1'b1; end
    else          begin rxd2 = b; rxv2 = 1'b1; end
    @(posedge clk); #1;
    rxv = 1'b0; rxv2 = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(0, a, 2); send_byte(0, b, 2); send_byte(0, c, 2);
    idle(8);
  endtask

  task automatic pkt4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d);
    send_byte(1, a, 2); send_byte(1, b, 2); send_byte(1, c, 2); send_byte(1, d, 2);
    idle(8);
  endtask

  initial begin
    #2 rst = 1'b1; rst2 = 1'b1;
    #1;
    chk("rst_cx", cx0, 0);   chk("rst_cy", cy0, 0);
    chk("rst_btn", bt0, 0);  chk("rst_wheel", wh0, 0);
    chk("rst_pv", pv0, 0);   chk("rst_mv", mv0, 0);  chk("rst_se", se0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rst2 = 1'b0;
    idle(2);

    // dx=+20: one step right, residue 5
    push(EV_PKT, 1, 0); push(EV_MOVE, 1, 0);
    pkt3(8'h09, 8'h14, 8'h00);
    // residue 5 + 14 = 19: just below threshold, no step
    push(EV_PKT, 0, 0);
    pkt3(8'h08, 8'h0E, 8'h00);
    // +1 reaches 20 exactly
    push(EV_PKT, 0, 0); push(EV_MOVE, 2, 0);
    pkt3(8'h08, 8'h01, 8'h00);
    // dy=-60: three steps down, residue -15
    push(EV_PKT, 0, 0);
    push(EV_MOVE, 2, 1); push(EV_MOVE, 2, 2); push(EV_MOVE, 2, 3);
    pkt3(8'h28, 8'h00, 8'hC4);
    // dy=-5 brings residue to -20 exactly
    push(EV_PKT, 0, 0); push(EV_MOVE, 2, 4);
    pkt3(8'h28, 8'h00, 8'hFB);

    // out-of-sync byte dropped, then a clean null packet
    push(EV_SYNC, 0, 0);
    send_byte(0, 8'h00, 2); idle(4);
    push(EV_PKT, 0, 0);
    pkt3(8'h08, 8'h00, 8'h00);

    // gap of exactly TO is tolerated; ax becomes 10
    push(EV_PKT, 1, 0);
    send_byte(0, 8'h09, 2); send_byte(0, 8'h05, TO); send_byte(0, 8'h00, 2);
    idle(8);
    // gap of TO+1 aborts; buttons hold and dx=5 is not applied
    push(EV_SYNC, 0, 0);
    send_byte(0, 8'h0A, 2); send_byte(0, 8'h05, TO + 1);
    idle(4);
    chk("btn_hold", bt0, 1);
    push(EV_PKT, 0, 0); push(EV_MOVE, 3, 4);
    pkt3(8'h08, 8'h0A, 8'h00);

    // inverted Y: mouse-up (+20) moves down; ay -5 -20 = -25
    inv = 1'b1;
    push(EV_PKT, 0, 0); push(EV_MOVE, 3, 5);
    pkt3(8'h08, 8'h00, 8'h14);
    inv = 1'b0;

    // receiver error mid-packet aborts
    push(EV_SYNC, 0, 0);
    send_byte(0, 8'h08, 2);
    rxe = 1'b1; @(posedge clk); #1 rxe = 1'b0;
    idle(4);
    push(EV_PKT, 1, 0);
    pkt3(8'h09, 8'h00, 8'h00);

    // X overflow bit drops dx, then +15 makes 20
    push(EV_PKT, 0, 0);
    pkt3(8'h48, 8'h7F, 8'h00);
    push(EV_PKT, 0, 0); push(EV_MOVE, 4, 5);
    pkt3(8'h08, 8'h0F, 8'h00);
    chk("q_drain_a", q.size(), 0);

    // edge behaviour: d0 clamps, d1 wraps
    rst = 1'b1; #1;
    chk("rst2_cx", cx0, 4'(0)); chk("rst2_cy", cy0, 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    push(EV_PKT, 0, 0);
    pkt3(8'h18, 8'hEC, 8'h00);
    chk("clamp_x", cx0, 0);
    chk("wrap_lo_x", cx1, 127);
    push(EV_PKT, 0, 0); push(EV_MOVE, 1, 0);
    pkt3(8'h08, 8'h19, 8'h00);
    chk("wrap_hi_x", cx1, 0);

    // wheel packets on d2
    pkt4(8'h0C, 8'h14, 8'h00, 8'h0F);
    chk("whl_wheel", wh2, 15);
    chk("whl_btn", bt2, 4);
    chk("whl_cx", cx2, 1);
    send_byte(1, 8'h09, 2); send_byte(1, 8'h14, 2); send_byte(1, 8'h00, 2);
    rst2 = 1'b1; #1;
    chk("mid_rst_cx", cx2, 0);  chk("mid_rst_cy", cy2, 0);
    chk("mid_rst_btn", bt2, 0); chk("mid_rst_wheel", wh2, 0);
    chk("mid_rst_pv", pv2, 0);  chk("mid_rst_mv", mv2, 0); chk("mid_rst_se", se2, 0);
    @(posedge clk); #1 rst2 = 1'b0;
    idle(2);
    pkt4(8'h0A, 8'h00, 8'h00, 8'h00);
    chk("post_rst_btn", bt2, 2);
    chk("post_rst_wheel", wh2, 0);
    chk("post_rst_cx", cx2, 0);

    idle(4);
    chk("q_drain_b", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
